// File: rtl/int8_to_float_arbiter.sv
// int8_to_float_arbiter: round-robin sharing of one int8->float converter, one block per grant,
// with source tags carried alongside the converter latency.
module int8_to_float_arbiter #(
  parameter int N_REQ       = 3,
  parameter int CVT_LATENCY = 2,
  parameter int BLOCK_LEN   = 64
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_REQ*8-1:0]         req_din,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 cvt_din,
  output logic                       cvt_din_valid,
  input  logic [31:0]                cvt_dout,
  input  logic                       cvt_dout_valid,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic                       out_last,
  output logic                       err_sync
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = BLOCK_LEN > 1 ? $clog2(BLOCK_LEN) : 1;
  typedef enum logic {ARB, BURST} state_t;
  state_t                 state;
  logic [IW-1:0]          grant, rr_ptr, win, cvt_id;
  logic [CW-1:0]          count;
  logic                   hit, beat, at_last, cvt_last;
  logic [7:0]             sel_byte;
  int                     best;
  logic [CVT_LATENCY-1:0] pv, plast;
  logic [IW-1:0]          pid [CVT_LATENCY];
  // best holds the round-robin distance from rr_ptr+1; the closest valid requester wins
  always_comb begin
    hit = 1'b0;
    win = '0;
    best = N_REQ;
    sel_byte = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (i + 2*N_REQ - 1 - int'(rr_ptr)) % N_REQ < best) begin
        best = (i + 2*N_REQ - 1 - int'(rr_ptr)) % N_REQ;
        win = IW'(i);
        hit = 1'b1;
      end
      if (grant == IW'(i)) begin
        sel_byte = req_din[8*i +: 8];
        req_ready[i] = (state == BURST) && req_valid[i];
      end
    end
  end
  assign beat    = |req_ready;
  assign at_last = count == CW'(BLOCK_LEN-1);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ARB;
      grant <= '0;
      rr_ptr <= IW'(N_REQ-1);
      count <= '0;
      cvt_din <= '0;
      cvt_din_valid <= 1'b0;
      cvt_id <= '0;
      cvt_last <= 1'b0;
    end else begin
      cvt_din_valid <= beat;
      cvt_id <= grant;
      cvt_last <= beat && at_last;
      if (beat) cvt_din <= sel_byte;
      if (state == ARB) begin
        if (hit) begin
          grant <= win;
          rr_ptr <= win;
          count <= '0;
          state <= BURST;
        end
      end else if (beat) begin
        count <= at_last ? '0 : count + 1'b1;
        if (at_last) state <= ARB;
      end
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pv <= '0;
      plast <= '0;
      for (int i = 0; i < CVT_LATENCY; i++) pid[i] <= '0;
      err_sync <= 1'b0;
    end else begin
      pv[0] <= cvt_din_valid;
      pid[0] <= cvt_id;
      plast[0] <= cvt_last;
      for (int i = 1; i < CVT_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pid[i] <= pid[i-1];
        plast[i] <= plast[i-1];
      end
      if (pv[CVT_LATENCY-1] != cvt_dout_valid) err_sync <= 1'b1;
    end
  end
  assign out_data  = cvt_dout;
  assign out_valid = cvt_dout_valid;
  assign out_id    = pv[CVT_LATENCY-1] ? pid[CVT_LATENCY-1] : '0;
  assign out_last  = pv[CVT_LATENCY-1] & plast[CVT_LATENCY-1];
endmodule

// File: tb/tb_int8_to_float_arbiter.sv
// tb_int8_to_float_arbiter: directed bench with requester counters and a variable-latency converter model.
module tb_int8_to_float_arbiter;
  localparam int N = 3;
  localparam int L = 2;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [N*8-1:0] req_din;
  logic [N-1:0] req_valid, req_ready, en = '0;
  logic [7:0] cvt_din;
  logic cvt_din_valid, cvt_dout_valid, out_valid, out_last, err_sync;
  logic [31:0] cvt_dout, out_data;
  logic [1:0] out_id;
  logic [5:0] idx [N];
  logic [7:0] dv;
  logic [7:0] dd [8];
  int lat = L;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int bad;
  int stamp_q[$];
  logic [7:0] din_q[$];
  logic [1:0] id_q[$];
  logic last_q[$];
  logic [31:0] data_q[$];
  always #5 clk = ~clk;
  int8_to_float_arbiter #(.N_REQ(N), .CVT_LATENCY(L), .BLOCK_LEN(64)) dut (
    .clk(clk), .nrst(nrst), .req_din(req_din), .req_valid(req_valid), .req_ready(req_ready),
    .cvt_din(cvt_din), .cvt_din_valid(cvt_din_valid), .cvt_dout(cvt_dout), .cvt_dout_valid(cvt_dout_valid),
    .out_data(out_data), .out_valid(out_valid), .out_id(out_id), .out_last(out_last), .err_sync(err_sync));
  function automatic logic [31:0] fconv(input logic [7:0] x);
    return {x, 8'h3C, ~x, 8'hA5};
  endfunction
  for (genvar g = 0; g < N; g++) begin : g_src
    assign req_din[8*g +: 8] = 8'(g*64) | {2'b00, idx[g]};
  end
  assign req_valid = en;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) for (int i = 0; i < N; i++) idx[i] <= '0;
    else for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) idx[i] <= idx[i] + 6'd1;
  end
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dv <= '0;
      for (int i = 0; i < 8; i++) dd[i] <= '0;
    end else begin
      dv <= {dv[6:0], cvt_din_valid};
      dd[0] <= cvt_din;
      for (int i = 1; i < 8; i++) dd[i] <= dd[i-1];
    end
  end
  assign cvt_dout_valid = dv[lat-1];
  assign cvt_dout = cvt_dout_valid ? fconv(dd[lat-1]) : 32'h0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (nrst) begin
      if (cvt_din_valid) begin
        din_q.push_back(cvt_din);
        stamp_q.push_back(cyc);
      end
      if (out_valid) begin
        id_q.push_back(out_id);
        last_q.push_back(out_last);
        data_q.push_back(out_data);
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_logs();
    stamp_q.delete();
    din_q.delete();
    id_q.delete();
    last_q.delete();
    data_q.delete();
  endtask
  task automatic do_reset(input int l);
    nrst = 1'b0;
    en = '0;
    lat = l;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    clear_logs();
  endtask
  task automatic wait_outs(input string tag, input int n);
    for (int c = 0; c < 2000 && id_q.size() < n; c++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 32'(id_q.size() >= n), 32'd1);
  endtask
  task automatic wait_idx(input string tag, input int r, input int v);
    for (int c = 0; c < 500 && int'(idx[r]) != v; c++) @(negedge clk);
    check(tag, 32'(idx[r]), 32'(v));
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_din_valid"}, 32'(cvt_din_valid), 32'd0);
    check({tag, "_din"}, 32'(cvt_din), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_id"}, 32'(out_id), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_err_sync"}, 32'(err_sync), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_quiet("reset");
    // single requester, full block
    do_reset(L);
    en = 3'b001;
    wait_outs("t1_wait", 64);
    bad = 0;
    for (int k = 0; k < 64; k++) if (din_q[k] !== 8'(k) || stamp_q[k] != stamp_q[0] + k) bad++;
    check("t1_din_seq", 32'(bad), 0);
    bad = 0;
    for (int k = 0; k < 64; k++) if (id_q[k] !== 2'd0 || last_q[k] !== (k == 63) || data_q[k] !== fconv(din_q[k])) bad++;
    check("t1_id_last_data", 32'(bad), 0);
    check("t1_last63", 32'(last_q[63]), 32'd1);
    check("t1_last_data", data_q[63], fconv(8'd63));
    check("t1_err_sync", 32'(err_sync), 32'd0);
    // all requesters valid: round robin 0,1,2,0
    do_reset(L);
    en = 3'b111;
    wait_outs("t2_wait", 256);
    bad = 0;
    for (int k = 0; k < 256; k++) if (id_q[k] !== 2'((k/64) % 3) || din_q[k] !== 8'(((k/64) % 3)*64 + k%64)) bad++;
    check("t2_order", 32'(bad), 0);
    bad = 0;
    for (int k = 1; k < 256; k++) if (stamp_q[k] - stamp_q[k-1] != ((k % 64 == 0) ? 2 : 1)) bad++;
    check("t2_gaps", 32'(bad), 0);
    check("t2_id192", 32'(id_q[192]), 32'd0);
    check("t2_id64", 32'(id_q[64]), 32'd1);
    // req1 drops valid for 5 cycles at beat 10 while req0 waits
    do_reset(L);
    en = 3'b010;
    wait_idx("t3_idx", 1, 10);
    en = 3'b001;
    repeat (5) @(negedge clk);
    en = 3'b011;
    wait_outs("t3_wait", 65);
    check("t3_bubble", 32'(stamp_q[10] - stamp_q[9]), 32'd6);
    check("t3_span", 32'(stamp_q[63] - stamp_q[0]), 32'd68);
    bad = 0;
    for (int k = 0; k < 64; k++) if (id_q[k] !== 2'd1 || last_q[k] !== (k == 63) || din_q[k] !== 8'(64 + k)) bad++;
    check("t3_block", 32'(bad), 0);
    check("t3_next_id", 32'(id_q[64]), 32'd0);
    // converter one cycle slower than the tag pipe
    do_reset(L + 1);
    en = 3'b001;
    wait_outs("t4_wait", 1);
    check("t4_err_first", 32'(err_sync), 32'd1);
    repeat (80) @(negedge clk);
    check("t4_err_sticky", 32'(err_sync), 32'd1);
    // reset mid-burst of req2
    do_reset(L);
    en = 3'b100;
    wait_idx("t5_idx", 2, 30);
    nrst = 1'b0;
    #1;
    check_quiet("t5_rst");
    en = 3'b101;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    clear_logs();
    wait_outs("t5_wait", 1);
    check("t5_first_id", 32'(id_q[0]), 32'd0);
    check("t5_first_din", 32'(din_q[0]), 32'd0);
    // only req2, back-to-back blocks
    do_reset(L);
    en = 3'b100;
    wait_outs("t6_wait", 192);
    bad = 0;
    for (int k = 0; k < 192; k++) if (id_q[k] !== 2'd2 || last_q[k] !== (k % 64 == 63) || din_q[k] !== 8'(128 + k%64)) bad++;
    check("t6_blocks", 32'(bad), 0);
    bad = 0;
    for (int k = 1; k < 192; k++) if (stamp_q[k] - stamp_q[k-1] != ((k % 64 == 0) ? 2 : 1)) bad++;
    check("t6_gaps", 32'(bad), 0);
    check("t6_err_sync", 32'(err_sync), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
